// File: rtl/sum_ascii_tx.sv
// Prints a small binary value (adder {carry, sum}) as two ASCII decimal digits plus a
// line terminator, one byte per valid/ready handshake.
module sum_ascii_tx #(
    parameter int          IN_W     = 6,
    parameter logic [7:0]  EOL_CHAR = 8'h0A,
    parameter logic [7:0]  PAD_CHAR = 8'h30
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_char,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONV   = 3'd1,
        S_SEND_T = 3'd2,
        S_SEND_O = 3'd3,
        S_SEND_E = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_nxt_state;
    logic        r_in_ready;
    logic        w_nxt_in_ready;
    logic        r_out_valid;
    logic        w_nxt_out_valid;
    logic [7:0]  r_out_char;
    logic [7:0]  w_nxt_out_char;
    logic [6:0]  r_rem;
    logic [6:0]  w_nxt_rem;
    logic [2:0]  r_tens;
    logic [2:0]  w_nxt_tens;

    logic        w_accept;
    logic        w_hs;
    logic [6:0]  w_in_ext;
    logic [7:0]  w_tens_char;
    logic [7:0]  w_ones_char;

    assign w_accept    = in_valid & r_in_ready;
    assign w_hs        = r_out_valid & out_ready;
    assign w_in_ext    = {{(7-IN_W){1'b0}}, in_data};
    assign w_tens_char = (r_tens == 3'd0) ? PAD_CHAR : (8'h30 + {5'b00000, r_tens});
    assign w_ones_char = 8'h30 + {4'b0000, r_rem[3:0]};

    // Next-state logic: conversion by repeated subtraction, then three handshaked bytes.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_rem       = r_rem;
        w_nxt_tens      = r_tens;
        w_nxt_out_valid = r_out_valid;
        w_nxt_out_char  = r_out_char;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nxt_state = S_CONV;
                    w_nxt_rem   = w_in_ext;
                    w_nxt_tens  = 3'd0;
                end else begin
                    w_nxt_state = S_IDLE;
                end
            end
            S_CONV: begin
                if (r_rem >= 7'd10) begin
                    w_nxt_rem  = r_rem - 7'd10;
                    w_nxt_tens = r_tens + 3'd1;
                end else begin
                    w_nxt_state     = S_SEND_T;
                    w_nxt_out_valid = 1'b1;
                    w_nxt_out_char  = w_tens_char;
                end
            end
            S_SEND_T: begin
                if (w_hs) begin
                    w_nxt_state    = S_SEND_O;
                    w_nxt_out_char = w_ones_char;
                end else begin
                    w_nxt_state = S_SEND_T;
                end
            end
            S_SEND_O: begin
                if (w_hs) begin
                    w_nxt_state    = S_SEND_E;
                    w_nxt_out_char = EOL_CHAR;
                end else begin
                    w_nxt_state = S_SEND_O;
                end
            end
            S_SEND_E: begin
                if (w_hs) begin
                    w_nxt_state     = S_IDLE;
                    w_nxt_out_valid = 1'b0;
                    w_nxt_out_char  = 8'h00;
                end else begin
                    w_nxt_state = S_SEND_E;
                end
            end
            default: begin
                w_nxt_state     = S_IDLE;
                w_nxt_out_valid = 1'b0;
                w_nxt_out_char  = 8'h00;
            end
        endcase
        // Registering the next-state decode makes in_ready rise one edge after reset release.
        w_nxt_in_ready = (w_nxt_state == S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_char  <= 8'h00;
            r_rem       <= 7'd0;
            r_tens      <= 3'd0;
        end else begin
            r_state     <= w_nxt_state;
            r_in_ready  <= w_nxt_in_ready;
            r_out_valid <= w_nxt_out_valid;
            r_out_char  <= w_nxt_out_char;
            r_rem       <= w_nxt_rem;
            r_tens      <= w_nxt_tens;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_char  = r_out_char;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sum_ascii_tx.sv
// Self-checking bench for sum_ascii_tx: values are printed and compared against a
// decimal-formatting reference model, under free-flowing and stalled sinks.
module tb_sum_ascii_tx;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic       busy;

    int errors = 0;
    int checks = 0;

    sum_ascii_tx #(.IN_W(6), .EOL_CHAR(8'h0A), .PAD_CHAR(8'h30)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal text of v, always two digits, then LF.
    function automatic logic [23:0] model_line(input int v);
        logic [7:0] t;
        logic [7:0] o;
        t = 8'(48 + v / 10);
        o = 8'(48 + v % 10);
        return {t, o, 8'h0A};
    endfunction

    // Waits (bounded) for in_ready and presents v for exactly one accept edge; returns at post-accept.
    task automatic send_value(input int v, output bit to);
        int n;
        n  = 0;
        to = 1'b0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) to = 1'b1;
        in_valid = 1'b1;
        in_data  = 6'(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Starting just after the accept edge, sinks one line. mode 0: always ready;
    // mode 1: random 3-cycle stalls; mode 2: always ready with a stray in_valid(7) held.
    task automatic collect_line(input int mode, output logic [23:0] line, output int lat,
                                output int viol, output int rdy_viol, output bit to);
        int         n;
        int         cyc;
        int         stall;
        logic       pv;
        logic       pr;
        logic [7:0] pc;
        logic       rdy;
        logic [7:0] got [3];
        n = 0; cyc = 0; stall = 3; pv = 1'b0; pr = 1'b0; pc = 8'h00;
        lat = -1; viol = 0; rdy_viol = 0; to = 1'b0;
        got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
        if (mode == 2) begin
            in_valid = 1'b1;
            in_data  = 6'd7;
        end
        while (n < 3) begin
            if (out_valid === 1'b1 && lat < 0) lat = cyc;
            if (pv === 1'b1 && pr === 1'b0 && (out_valid !== 1'b1 || out_char !== pc)) viol++;
            if (in_ready !== 1'b0 || busy !== 1'b1) rdy_viol++;
            if (mode == 1) begin
                if (out_valid === 1'b1 && stall > 0) begin
                    rdy = 1'b0;
                    stall--;
                end else if (out_valid !== 1'b1) begin
                    rdy = 1'($urandom_range(0, 1));
                end else begin
                    rdy = 1'b1;
                end
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            if (out_valid === 1'b1 && rdy) begin
                got[n] = out_char;
                n++;
                stall = ($urandom_range(0, 1) == 1) ? 3 : 0;
                if (n == 3) in_valid = 1'b0;
            end
            pv = out_valid; pr = rdy; pc = out_char;
            @(posedge clk); #1; cyc++;
            if (cyc > 80) begin
                to = 1'b1;
                break;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        line = {got[0], got[1], got[2]};
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 6'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_char !== 8'h00 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b c=%h r=%b b=%b want 0 00 0 0", out_valid, out_char, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_release: got r=%b b=%b want 1 0", in_ready, busy);
        end
    endtask

    // Values: 62, 0, 63 fixed, then randoms; all with the sink always ready.
    task automatic test_values;
        int          vals [$];
        logic [23:0] line;
        int          lat, viol, rv;
        bit          to1, to2;
        vals = '{62, 0, 63};
        for (int i = 0; i < 5; i++) vals.push_back(int'($urandom_range(0, 63)));
        foreach (vals[i]) begin
            send_value(vals[i], to1);
            collect_line(0, line, lat, viol, rv, to2);
            checks++;
            if (line !== model_line(vals[i]) || to1 || to2) begin
                errors++;
                $display("FAIL line_%0d: got %h want %h (timeout %0d/%0d)", vals[i], line, model_line(vals[i]), to1, to2);
            end
            checks++;
            if (lat !== vals[i] / 10 + 1) begin
                errors++;
                $display("FAIL latency_%0d: got %0d want %0d", vals[i], lat, vals[i] / 10 + 1);
            end
            checks++;
            if (rv !== 0 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_char !== 8'h00) begin
                errors++;
                $display("FAIL idle_after_%0d: got rdyviol=%0d r=%b b=%b v=%b c=%h want 0 1 0 0 00", vals[i], rv, in_ready, busy, out_valid, out_char);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] line;
        int          lat, viol, rv;
        bit          to1, to2;
        int          v;
        for (int i = 0; i < 2; i++) begin
            v = (i == 0) ? 9 : 10;
            send_value(v, to1);
            collect_line(0, line, lat, viol, rv, to2);
            checks++;
            if (line !== model_line(v) || lat !== v / 10 + 1 || to1 || to2) begin
                errors++;
                $display("FAIL b2b_%0d: got %h lat %0d want %h lat %0d", v, line, lat, model_line(v), v / 10 + 1);
            end
            checks++;
            if (rv !== 0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d: got rdyviol=%0d r=%b want 0 1", v, rv, in_ready);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [23:0] line;
        int          lat, viol, rv;
        bit          to1, to2;
        for (int k = 0; k < 3; k++) begin
            int v;
            v = (k == 0) ? 25 : int'($urandom_range(0, 63));
            send_value(v, to1);
            collect_line(1, line, lat, viol, rv, to2);
            checks++;
            if (line !== model_line(v) || to1 || to2) begin
                errors++;
                $display("FAIL bp_line_%0d: got %h want %h", v, line, model_line(v));
            end
            checks++;
            if (viol !== 0) begin
                errors++;
                $display("FAIL bp_stable_%0d: got %0d stall violations want 0", v, viol);
            end
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bp_extra_%0d: got v=%b b=%b want 0 0", v, out_valid, busy);
            end
        end
    endtask

    task automatic test_ignore;
        logic [23:0] line;
        int          lat, viol, rv;
        bit          to1, to2;
        send_value(41, to1);
        collect_line(2, line, lat, viol, rv, to2);
        checks++;
        if (line !== model_line(41) || to1 || to2) begin
            errors++;
            $display("FAIL ignore_line: got %h want %h", line, model_line(41));
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_accept: got b=%b v=%b want 0 0", busy, out_valid);
        end
        send_value(33, to1);
        collect_line(0, line, lat, viol, rv, to2);
        checks++;
        if (line !== model_line(33) || lat !== 4 || to1 || to2) begin
            errors++;
            $display("FAIL ignore_next: got %h lat %0d want %h lat 4", line, lat, model_line(33));
        end
    endtask

    task automatic test_reset_mid;
        logic [23:0] line;
        int          lat, viol, rv;
        bit          to1, to2;
        int          n;
        send_value(57, to1);
        out_ready = 1'b1;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_char !== 8'h37 || to1) begin
            errors++;
            $display("FAIL mid_ones: got v=%b c=%h want 1 37", out_valid, out_char);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_char !== 8'h00 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b c=%h r=%b b=%b want 0 00 0 0", out_valid, out_char, in_ready, busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 6'd12;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_no_accept: got r=%b b=%b v=%b want 1 0 0", in_ready, busy, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL release_accept: got r=%b b=%b want 0 1", in_ready, busy);
        end
        collect_line(0, line, lat, viol, rv, to2);
        checks++;
        if (line !== model_line(12) || lat !== 2 || to2) begin
            errors++;
            $display("FAIL after_reset_line: got %h lat %0d want %h lat 2", line, lat, model_line(12));
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_back_to_back();
        test_backpressure();
        test_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
